// File: rtl/prio_enc_scan.sv
// Registered priority scanner: captures an N-bit request vector through a
// valid/ready handshake, then emits the index of each set bit (one per
// accepted output beat) in priority order. An all-zero vector yields a
// single beat flagged with out_none.
module prio_enc_scan #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] pend;
  logic         none_r;

  logic         capture;
  logic         accept;
  logic         emitting;

  // Index of the highest-priority set bit; returns 0 for an empty vector.
  function automatic logic [W-1:0] prio_index(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      // Ascending sweep: the last hit is the highest set index.
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      // Descending sweep: the last hit is the lowest set index.
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
    return idx;
  endfunction

  // True when at most one bit of the vector is set (clearing the lowest
  // set bit leaves nothing behind).
  function automatic logic at_most_one(input logic [N-1:0] vec);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return ((vec & (vec - one)) == '0);
  endfunction

  // Output decode and handshake qualifiers; everything derives from state,
  // pend and none_r, never from in_vec, so the output side has no
  // combinational dependency on the input vector.
  always_comb begin
    emitting  = (state == EMIT);
    busy      = emitting;
    out_valid = en & emitting;
    out_idx   = prio_index(pend);
    out_last  = emitting & at_most_one(pend);
    out_none  = emitting & none_r;
    accept    = out_valid & out_ready;
    // The out_ready -> in_ready path lets a new vector be captured on the
    // same edge that retires the final beat, so consecutive vectors stream
    // without a bubble.
    in_ready  = en & (~emitting | (accept & out_last));
    capture   = in_valid & in_ready;
  end

  // Scan state machine: capture loads a fresh vector, each accepted beat
  // clears the emitted bit, the final beat returns to IDLE unless a new
  // capture happens on the same edge. en=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      none_r <= 1'b0;
    end else if (en) begin
      if (capture) begin
        pend   <= in_vec;
        none_r <= (in_vec == '0);
        state  <= EMIT;
      end else if (accept) begin
        pend[out_idx] <= 1'b0;
        if (out_last) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed bench for prio_enc_scan. Two instances share one stimulus: an
// LSB-first scanner and an MSB-first scanner (beat counts match, so their
// handshakes stay in lockstep).
module tb_prio_enc_scan;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic [N-1:0] in_vec;
  logic         out_ready;

  logic         in_ready_l, out_valid_l, out_last_l, out_none_l, busy_l;
  logic [W-1:0] out_idx_l;
  logic         in_ready_m, out_valid_m, out_last_m, out_none_m, busy_m;
  logic [W-1:0] out_idx_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_enc_scan #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .in_vec    (in_vec),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_idx   (out_idx_l),
    .out_last  (out_last_l),
    .out_none  (out_none_l),
    .busy      (busy_l)
  );

  prio_enc_scan #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_vec    (in_vec),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_idx   (out_idx_m),
    .out_last  (out_last_m),
    .out_none  (out_none_m),
    .busy      (busy_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LSB-instance beat check: valid, index, last, none.
  task automatic beat_l(input string tag, input int idx, input bit last, input bit none);
    chk({tag, "_valid"}, 32'(out_valid_l), 32'd1);
    chk({tag, "_idx"},   32'(out_idx_l),   32'(idx));
    chk({tag, "_last"},  32'(out_last_l),  32'(last));
    chk({tag, "_none"},  32'(out_none_l),  32'(none));
  endtask

  task automatic beat_m(input string tag, input int idx, input bit last);
    chk({tag, "_valid"}, 32'(out_valid_m), 32'd1);
    chk({tag, "_idx"},   32'(out_idx_m),   32'(idx));
    chk({tag, "_last"},  32'(out_last_m),  32'(last));
  endtask

  task automatic idle_l(input string tag);
    chk({tag, "_valid"}, 32'(out_valid_l), 32'd0);
    chk({tag, "_busy"},  32'(busy_l),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid_l), 32'd0);
    chk("rst_idx",   32'(out_idx_l),   32'd0);
    chk("rst_last",  32'(out_last_l),  32'd0);
    chk("rst_none",  32'(out_none_l),  32'd0);
    chk("rst_busy",  32'(busy_l),      32'd0);
    chk("rst_ready", 32'(in_ready_l),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1/2: 1010_0100 -> LSB 2,5,7 ; MSB 7,5,2
    in_vec   = 8'b1010_0100;
    in_valid = 1'b1;
    #1;
    chk("t1_pre_ready", 32'(in_ready_l),  32'd1);
    chk("t1_pre_valid", 32'(out_valid_l), 32'd0);
    tick();
    in_valid = 1'b0;
    beat_l("t1_b0", 2, 1'b0, 1'b0);
    beat_m("t2_b0", 7, 1'b0);
    tick();
    beat_l("t1_b1", 5, 1'b0, 1'b0);
    beat_m("t2_b1", 5, 1'b0);
    tick();
    beat_l("t1_b2", 7, 1'b1, 1'b0);
    beat_m("t2_b2", 2, 1'b1);
    chk("t1_last_ready", 32'(in_ready_l), 32'd1);
    tick();
    idle_l("t1_end");
    chk("t2_end_valid", 32'(out_valid_m), 32'd0);

    // Test 3: zero vector -> single beat with out_none
    in_vec   = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat_l("t3_b0", 0, 1'b1, 1'b1);
    tick();
    idle_l("t3_end");

    // Test 4: backpressure on first beat of 8'h81
    in_vec    = 8'h81;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_vec = 8'hFF;  // must be ignored while holding
    for (int i = 0; i < 5; i++) begin
      beat_l("t4_hold", 0, 1'b0, 1'b0);
      chk("t4_hold_ready", 32'(in_ready_l), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    beat_l("t4_rel0", 0, 1'b0, 1'b0);
    tick();
    beat_l("t4_rel1", 7, 1'b1, 1'b0);
    tick();
    idle_l("t4_end");

    // Test 5: back-to-back 8'h03 then 8'h40 with in_valid held high
    in_vec   = 8'h03;
    in_valid = 1'b1;
    tick();
    in_vec = 8'h40;
    beat_l("t5_b0", 0, 1'b0, 1'b0);
    chk("t5_b0_ready", 32'(in_ready_l), 32'd0);
    tick();
    beat_l("t5_b1", 1, 1'b1, 1'b0);
    chk("t5_b1_ready", 32'(in_ready_l), 32'd1);
    tick();
    in_valid = 1'b0;
    beat_l("t5_b2", 6, 1'b1, 1'b0);
    tick();
    idle_l("t5_end");

    // All-ones: N beats, last only on the Nth
    in_vec   = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      beat_l("ones_l", i, (i == N - 1), 1'b0);
      beat_m("ones_m", N - 1 - i, (i == N - 1));
      tick();
    end
    idle_l("ones_end");

    // Test 6: en=0 freeze after 3 beats, then reset mid-scan
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat_l("t6_pre", i, 1'b0, 1'b0);
      tick();
    end
    en = 1'b0;
    #1;
    chk("t6_off_valid", 32'(out_valid_l), 32'd0);
    chk("t6_off_ready", 32'(in_ready_l),  32'd0);
    chk("t6_off_busy",  32'(busy_l),      32'd1);
    tick();
    tick();
    chk("t6_off2_valid", 32'(out_valid_l), 32'd0);
    en = 1'b1;
    #1;
    beat_l("t6_resume", 3, 1'b0, 1'b0);
    tick();
    beat_l("t6_next", 4, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    idle_l("t6_rst");
    chk("t6_rst_idx",  32'(out_idx_l),  32'd0);
    chk("t6_rst_last", 32'(out_last_l), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    idle_l("t6_after");
    chk("t6_after_ready", 32'(in_ready_l), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
